// File: rtl/mux8b16_pkg.sv
// mux8b16_pkg: shared constants and types for the registered one-hot 8:1 selector
package mux8b16_pkg;
    localparam int WIDTH_DEFAULT = 16;
    localparam logic [7:0] SEL_A = 8'h01;
    localparam logic [7:0] SEL_B = 8'h02;
    localparam logic [7:0] SEL_C = 8'h04;
    localparam logic [7:0] SEL_D = 8'h08;
    localparam logic [7:0] SEL_E = 8'h10;
    localparam logic [7:0] SEL_F = 8'h20;
    localparam logic [7:0] SEL_G = 8'h40;
    localparam logic [7:0] SEL_H = 8'h80;
    typedef logic [WIDTH_DEFAULT-1:0] data_t;
    typedef logic [7:0] sel_t;
endpackage

// File: rtl/mux8_onehot16_onehot_check.sv
// onehot_check: flags whether an 8-bit select has exactly one bit set
module onehot_check
    import mux8b16_pkg::*;
(
    input  sel_t s,
    output logic is_onehot
);
    // clearing the lowest set bit leaves zero only for powers of two
    always_comb is_onehot = (s != 8'd0) && ((s & (s - 8'd1)) == 8'd0);
endmodule

// File: rtl/mux8_onehot16.sv
// mux8_onehot16: registered 8-way AND-OR selector with a not-one-hot status flag
module mux8_onehot16
    import mux8b16_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int NUM_IN = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  sel_t             S,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] F,
    input  logic [WIDTH-1:0] G,
    input  logic [WIDTH-1:0] H,
    output logic [WIDTH-1:0] O,
    output logic             SEL_ERR
);
    logic [WIDTH-1:0] ins [NUM_IN];
    logic [WIDTH-1:0] o_next;
    logic             is_onehot;

    assign ins = '{A, B, C, D, E, F, G, H};

    onehot_check u_check (
        .s        (S),
        .is_onehot(is_onehot)
    );

    // gate each input by its select bit and OR; multi-hot selects merge, no priority
    always_comb begin
        o_next = '0;
        for (int i = 0; i < NUM_IN; i++)
            o_next = o_next | ({WIDTH{S[i]}} & ins[i]);
    end

    // capture data and its status together so the flag describes the O it accompanies
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            O       <= '0;
            SEL_ERR <= 1'b0;
        end else begin
            O       <= o_next;
            SEL_ERR <= ~is_onehot;
        end
    end
endmodule

// File: tb/tb_mux8_onehot16.sv
// tb_mux8_onehot16: directed-vector check of the registered one-hot selector
module tb_mux8_onehot16;
    import mux8b16_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    sel_t        S = 8'h00;
    logic [15:0] A, B, C, D, E, F, G, H;
    logic [15:0] O;
    logic        SEL_ERR;
    int          n_cmp = 0;
    int          n_bad = 0;

    mux8_onehot16 dut (
        .CLK(CLK), .RESET_N(RESET_N), .S(S),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H),
        .O(O), .SEL_ERR(SEL_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input sel_t sel);
        S = sel;
        @(posedge CLK);
        #1;
    endtask

    logic [15:0] exp_seq [7] = '{16'd5, 16'd10, 16'd15, 16'd20, 16'd25, 16'd30, 16'd35};

    initial begin
        {A, B, C, D, E, F, G, H} = {16'd5, 16'd10, 16'd15, 16'd20, 16'd25, 16'd30, 16'd35, 16'd40};
        #1;
        check("reset_o", O, 0);
        check("reset_err", SEL_ERR, 0);
        @(posedge CLK);
        #1;
        check("reset_hold_o", O, 0);
        @(negedge CLK);
        RESET_N = 1'b1;

        step(SEL_H);
        check("sel_h_o", O, 40);
        check("sel_h_err", SEL_ERR, 0);

        for (int i = 0; i < 7; i++) begin
            logic [7:0] one;
            one = 8'h01 << i;
            step(one);
            check($sformatf("walk%0d_o", i), O, exp_seq[i]);
            check($sformatf("walk%0d_err", i), SEL_ERR, 0);
        end

        step(8'h00);
        check("zero_o", O, 0);
        check("zero_err", SEL_ERR, 1);
        step(SEL_E);
        check("sel_e_o", O, 25);
        check("sel_e_err", SEL_ERR, 0);

        step(8'h03);
        check("ab_o", O, 15);
        check("ab_err", SEL_ERR, 1);
        step(8'hFF);
        check("all_o", O, 16'h003F);
        check("all_err", SEL_ERR, 1);

        #2;
        RESET_N = 1'b0;
        #1;
        check("async_err_clr", SEL_ERR, 0);
        check("async_o_clr", O, 0);
        RESET_N = 1'b1;

        step(SEL_H);
        check("pre_rst_o", O, 40);
        #2;
        RESET_N = 1'b0;
        #1;
        check("mid_rst_o", O, 0);
        check("mid_rst_err", SEL_ERR, 0);
        S = 8'h00;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("rst_hold_o", O, 0);
        check("rst_hold_err", SEL_ERR, 0);
        S = SEL_C;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        check("post_rst_o", O, 15);
        check("post_rst_err", SEL_ERR, 0);

        step(SEL_F);
        check("sel_f_o", O, 30);
        F = 16'hFFFF;
        #2;
        check("f_no_early", O, 30);
        step(SEL_F);
        check("f_new_o", O, 16'hFFFF);
        {A, B, C, D, E} = {16'hDEAD, 16'hBEEF, 16'h1234, 16'h8001, 16'h0F0F};
        {G, H} = {16'hA5A5, 16'h5A5A};
        step(SEL_F);
        check("f_isolated_o", O, 16'hFFFF);
        check("f_isolated_err", SEL_ERR, 0);
        step(8'h21);
        check("af_o", O, 16'hFFFF);
        check("af_err", SEL_ERR, 1);
        step(8'hC0);
        check("gh_o", O, 16'hFFFF);
        step(8'h06);
        check("bc_o", O, 16'hBEEF | 16'h1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
